// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM request controller and the memory-array side.
//   SRAM_BW_DATA / SRAM_BW_ADDR : default data width and word-address width
//   SRAM_ROW_BITS               : low address bits that pick a row within a bank;
//                                 the bits above them pick the bank
//   sram_state_e                : controller FSM state encoding
//   sram_depth()                : number of words for a given address width
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int SRAM_BW_DATA  = 64;
  localparam int SRAM_BW_ADDR  = 6;
  localparam int SRAM_ROW_BITS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RSP_HOLD = 2'd2,
    CLEAR    = 2'd3
  } sram_state_e;

  function automatic int sram_depth(input int bw_addr);
    return 1 << bw_addr;
  endfunction

endpackage

// File: rtl/sram_addr_cnt.sv
// -----------------------------------------------------------------------------
// sram_addr_cnt
// Address counter that walks the memory during a zero-fill.
//   i_clk   : clock, rising edge
//   i_clr   : synchronous clear to 0 (has priority over i_inc)
//   i_inc   : advance by one
//   o_count : current count, one bit wider than the word address so the top
//             address can be reached without wrapping back to 0
//   o_last  : count equals the highest word address
// -----------------------------------------------------------------------------
module sram_addr_cnt
  import sram_pkg::*;
#(
  parameter int BW_ADDR = SRAM_BW_ADDR
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [BW_ADDR:0] o_count,
  output logic             o_last
);

  localparam logic [BW_ADDR:0] LAST_ADDR = {1'b0, {BW_ADDR{1'b1}}};
  localparam logic [BW_ADDR:0] ONE       = {{BW_ADDR{1'b0}}, 1'b1};

  logic [BW_ADDR:0] count_q;
  logic [BW_ADDR:0] count_d;

  // Saturates once the extra top bit is set, so a stray increment can never
  // fold the count back onto address 0.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && !count_q[BW_ADDR]) begin
      count_d = count_q + ONE;
    end
  end

  // The owner drives i_clr from its reset, so no separate reset is needed here.
  always_ff @(posedge i_clk) begin
    count_q <= count_d;
  end

  assign o_count = count_q;
  assign o_last  = (count_q == LAST_ADDR);

endmodule

// File: rtl/sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl
// Single-port SRAM request controller: accepts read/write requests, issues
// memory strobes, returns read data over a valid/ready response channel and
// can zero-fill the whole memory on request.
//   i_clk, i_rst              : clock and synchronous active-high reset
//   i_req_valid/o_req_ready   : request handshake
//   i_req_wr/addr/wdata       : request type (1 = write), word address, data
//   i_clr / o_clr_busy        : start zero-fill (pulse) / zero-fill running
//   o_rsp_valid/i_rsp_ready   : read response handshake
//   o_rsp_rdata               : read response data, stable while valid
//   o_mem_addr/wdata          : memory address and write data (0 when idle)
//   o_mem_wen / o_mem_oen     : one-cycle write strobe / read enable
//   i_mem_rdata               : memory read data, valid the cycle after oen
// The address space is flat; the upper address bits select a bank in the
// array, which this block does not decode.
// -----------------------------------------------------------------------------
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int BW_DATA = SRAM_BW_DATA,
  parameter int BW_ADDR = SRAM_BW_ADDR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [BW_ADDR-1:0] i_req_addr,
  input  logic [BW_DATA-1:0] i_req_wdata,
  input  logic               i_clr,
  output logic               o_clr_busy,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [BW_DATA-1:0] o_rsp_rdata,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_wdata,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  input  logic [BW_DATA-1:0] i_mem_rdata
);

  localparam int LANES = BW_DATA / 32;

  sram_state_e        state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [BW_DATA-1:0] rsp_rdata_q, rsp_rdata_d;

  logic               req_ready;
  logic               wr_acc;
  logic               rd_acc;
  logic               clr_wen;
  logic               cnt_clr;
  logic               cnt_inc;
  logic [BW_ADDR:0]   cnt;
  logic               cnt_last;

  // The counter sits at 0 whenever the FSM is outside CLEAR, so entering
  // CLEAR always starts from address 0 and an aborted fill never resumes.
  assign cnt_clr = i_rst || (state_q != CLEAR);

  sram_addr_cnt #(
    .BW_ADDR (BW_ADDR)
  ) u_addr_cnt (
    .i_clk   (i_clk),
    .i_clr   (cnt_clr),
    .i_inc   (cnt_inc),
    .o_count (cnt),
    .o_last  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    clr_wen     = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A clear pulse takes priority: ready drops so a coincident request
        // is simply not accepted and the requester keeps it pending.
        req_ready = !i_clr;
        if (i_clr) begin
          state_d = CLEAR;
        end else if (i_req_valid) begin
          if (i_req_wr) begin
            wr_acc = 1'b1;
          end else begin
            rd_acc  = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        rsp_rdata_d = i_mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = RSP_HOLD;
      end

      RSP_HOLD: begin
        // Ready stays low through the handshake cycle; the next request is
        // taken one cycle later, back in IDLE.
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      CLEAR: begin
        // The extra counter bit guards against writing past the top address.
        clr_wen = !cnt[BW_ADDR];
        cnt_inc = 1'b1;
        if (cnt_last) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing reaches the memory or the request port while reset is held.
    if (i_rst) begin
      req_ready = 1'b0;
      wr_acc    = 1'b0;
      rd_acc    = 1'b0;
      clr_wen   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign o_req_ready = req_ready;
  assign o_clr_busy  = (state_q == CLEAR);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_mem_wen   = wr_acc || clr_wen;
  assign o_mem_oen   = rd_acc;

  // Address is parked at 0 unless an access is actually being driven.
  always_comb begin
    o_mem_addr = '0;
    if (wr_acc || rd_acc) begin
      o_mem_addr = i_req_addr;
    end else if (clr_wen) begin
      o_mem_addr = cnt[BW_ADDR-1:0];
    end
  end

  // Write data is forced to 0 outside an accepted write, which also gives the
  // zero-fill its data for free.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_wdata_lane
    assign o_mem_wdata[gi*32 +: 32] = wr_acc ? i_req_wdata[gi*32 +: 32] : 32'd0;
  end

endmodule
